// File: rtl/vram_fast_mp.sv
// vram_fast_mp: multi-port single-access video RAM with round-robin arbitration,
// a pipelined read return path and an optional zero-fill after every reset.
module vram_fast_mp #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 11,
    parameter int PORTS      = 2,
    parameter int RD_LAT     = 2,
    parameter int AUTO_CLEAR = 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [PORTS-1:0]         REQ,
    input  logic [PORTS-1:0]         WE,
    input  logic [PORTS*ADDR_W-1:0]  ADDR,
    input  logic [PORTS*DATA_W-1:0]  WDATA,
    output logic [PORTS-1:0]         ACK,
    output logic [DATA_W-1:0]        RDATA,
    output logic [PORTS-1:0]         RVALID,
    output logic                     READY
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [PTR_W-1:0]    ptr;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   addr_a  [PORTS];
    logic [DATA_W-1:0]   wdata_a [PORTS];

    logic [PORTS-1:0]    grant;
    logic                found;
    logic [PTR_W-1:0]    arb_idx;
    logic [PTR_W-1:0]    ptr_nxt;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic                acc_rd;
    logic                acc_wr;

    // Read return pipeline: stage 0 is the array sample taken at the accept edge.
    logic [DATA_W-1:0]   dat_p [RD_LAT];
    logic [PORTS-1:0]    vld_p [RD_LAT];

    // RESET gates READY directly so grants stop the instant reset rises.
    assign READY = (state == ST_RUN) && !RESET;

    // Unpack the flat per-port buses into arrays indexed by port number.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            addr_a[p]  = ADDR[p*ADDR_W +: ADDR_W];
            wdata_a[p] = WDATA[p*DATA_W +: DATA_W];
        end
    end

    // Round-robin search: first requester at or after ptr, wrapping to port 0.
    always_comb begin
        grant     = '0;
        found     = 1'b0;
        arb_idx   = '0;
        ptr_nxt   = ptr;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            arb_idx = PTR_W'((int'(ptr) + k) % PORTS);
            if (!found && REQ[arb_idx]) begin
                found          = 1'b1;
                grant[arb_idx] = 1'b1;
                sel_addr       = addr_a[arb_idx];
                sel_wdata      = wdata_a[arb_idx];
                sel_we         = WE[arb_idx];
                ptr_nxt        = PTR_W'((int'(arb_idx) + 1) % PORTS);
            end
        end
    end

    assign ACK    = READY ? grant : '0;
    assign acc_rd = (|ACK) && !sel_we;
    assign acc_wr = (|ACK) && sel_we;

    // Control FSM: zero-fill sweep after reset, then normal arbitration.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= (AUTO_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
            ptr     <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == {ADDR_W{1'b1}})
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (|ACK)
                        ptr <= ptr_nxt;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Array port plus read data stages; data carries no reset, only valids do.
    always_ff @(posedge CLK) begin
        if (state == ST_CLEAR && !RESET)
            mem[clr_cnt] <= '0;
        else if (acc_wr)
            mem[sel_addr] <= sel_wdata;
        // p0: sample the array at the accept edge, before any later write
        if (acc_rd)
            dat_p[0] <= mem[sel_addr];
        // p1..: carry the sampled word toward the output register
        for (int i = 1; i < RD_LAT; i++)
            dat_p[i] <= dat_p[i-1];
    end

    // Valid/owner pipeline and output register; RDATA holds between returns.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < RD_LAT; i++)
                vld_p[i] <= '0;
            RVALID <= '0;
            RDATA  <= '0;
        end else begin
            vld_p[0] <= acc_rd ? ACK : '0;
            for (int i = 1; i < RD_LAT; i++)
                vld_p[i] <= vld_p[i-1];
            // output stage: RD_LAT edges after acceptance
            RVALID <= vld_p[RD_LAT-1];
            if (|vld_p[RD_LAT-1])
                RDATA <= dat_p[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_vram_fast_mp.sv
// Testbench for vram_fast_mp: directed scenarios plus random traffic, all
// checked against a behavioural memory/arbiter/return-queue model.
module tb_vram_fast_mp;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 11;
    localparam int PORTS  = 2;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                    CLK = 1'b0;
    logic                    RESET = 1'b1;
    logic [PORTS-1:0]        REQ = '0;
    logic [PORTS-1:0]        WE = '0;
    logic [PORTS*ADDR_W-1:0] ADDR = '0;
    logic [PORTS*DATA_W-1:0] WDATA = '0;
    logic [PORTS-1:0]        ACK;
    logic [DATA_W-1:0]       RDATA;
    logic [PORTS-1:0]        RVALID;
    logic                    READY;

    vram_fast_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PORTS(PORTS),
        .RD_LAT(RD_LAT), .AUTO_CLEAR(1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .ADDR(ADDR),
        .WDATA(WDATA), .ACK(ACK), .RDATA(RDATA), .RVALID(RVALID), .READY(READY)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model
    typedef struct {
        int                 due;
        int                 port;
        logic [DATA_W-1:0]  data;
    } ret_t;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    ret_t              rq[$];
    int                m_ptr;
    int                clr_left;
    int                edge_n;
    logic [DATA_W-1:0] last_rd;
    int                grants [PORTS];

    // Pending requester intent per port
    bit                p_act  [PORTS];
    bit                p_we   [PORTS];
    logic [ADDR_W-1:0] p_addr [PORTS];
    logic [DATA_W-1:0] p_wd   [PORTS];
    bit                auto_mode = 1'b0;

    function automatic int exp_grant();
        if (clr_left > 0) return -1;
        for (int k = 0; k < PORTS; k++) begin
            int idx;
            idx = (m_ptr + k) % PORTS;
            if (p_act[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic req(input int p, input bit we, input int a, input int d);
        p_act[p]  = 1'b1;
        p_we[p]   = we;
        p_addr[p] = ADDR_W'(a);
        p_wd[p]   = DATA_W'(d);
    endtask

    task automatic drive();
        for (int p = 0; p < PORTS; p++) begin
            REQ[p] = p_act[p];
            WE[p]  = p_we[p];
            ADDR[p*ADDR_W +: ADDR_W] = p_addr[p];
            WDATA[p*DATA_W +: DATA_W] = p_wd[p];
        end
    endtask

    task automatic gen_random();
        for (int p = 0; p < PORTS; p++) begin
            if (p_act[p] && ($urandom % 8 == 0)) begin
                p_act[p] = 1'b0;
            end else if (!p_act[p] && ($urandom % 3 != 0)) begin
                req(p, bit'($urandom % 2),
                    ($urandom % 4 == 0) ? int'($urandom % DEPTH) : int'($urandom % 16),
                    int'($urandom % 256));
            end
        end
    endtask

    // One clock, entered and left at a falling edge.
    task automatic cycle();
        int g;
        ret_t r;
        if (auto_mode) gen_random();
        drive();
        #1;
        g = exp_grant();
        chk("ack", 32'(ACK), (g < 0) ? 0 : (1 << g));
        chk("ready", 32'(READY), (clr_left == 0) ? 1 : 0);
        @(posedge CLK);
        edge_n++;
        if (clr_left > 0) clr_left--;
        if (g >= 0) begin
            grants[g]++;
            if (p_we[g]) ref_mem[p_addr[g]] = p_wd[g];
            else rq.push_back('{due: edge_n + RD_LAT, port: g, data: ref_mem[p_addr[g]]});
            m_ptr = (g + 1) % PORTS;
            p_act[g] = 1'b0;
        end
        @(negedge CLK);
        if (rq.size() > 0 && rq[0].due == edge_n) begin
            r = rq.pop_front();
            chk("rvalid", 32'(RVALID), 1 << r.port);
            chk("rdata", 32'(RDATA), 32'(r.data));
            last_rd = r.data;
        end else begin
            chk("rvalid_idle", 32'(RVALID), 0);
            chk("rdata_hold", 32'(RDATA), 32'(last_rd));
        end
    endtask

    task automatic do_reset(input int hold);
        RESET = 1'b1;
        for (int p = 0; p < PORTS; p++) p_act[p] = 1'b0;
        drive();
        #1;
        chk("rst_ack", 32'(ACK), 0);
        chk("rst_rvalid", 32'(RVALID), 0);
        chk("rst_rdata", 32'(RDATA), 0);
        chk("rst_ready", 32'(READY), 0);
        repeat (hold) @(negedge CLK);
        RESET = 1'b0;
        rq.delete();
        m_ptr    = 0;
        clr_left = DEPTH;
        last_rd  = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        edge_n = 0;
        for (int p = 0; p < PORTS; p++) begin
            p_act[p] = 0; p_we[p] = 0; p_addr[p] = '0; p_wd[p] = '0; grants[p] = 0;
        end
        @(negedge CLK);
        do_reset(3);
        // reset in the middle of the clear sweep restarts it from address 0
        idle(100);
        do_reset(2);
        idle(DEPTH + 2);

        // freshly cleared array reads back zero at low, middle and top
        req(0, 0, 'h000, 0); cycle();
        req(0, 0, 'h3FF, 0); cycle();
        req(0, 0, 'h7FF, 0); cycle();
        idle(4);

        // write on port 0, read-back on port 1 at the next edge
        req(0, 1, 'h123, 'h5A); cycle();
        req(1, 0, 'h123, 0);    cycle();
        idle(4);

        // both ports requesting continuously share grants evenly
        for (int p = 0; p < PORTS; p++) grants[p] = 0;
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < PORTS; p++)
                if (!p_act[p]) req(p, 0, int'($urandom % 16), 0);
            cycle();
        end
        chk("fair_p0", 32'(grants[0]), 20);
        chk("fair_p1", 32'(grants[1]), 20);
        for (int p = 0; p < PORTS; p++) p_act[p] = 0;
        idle(4);

        // read already in flight is not disturbed by a following write
        req(0, 1, 'h010, 'h11); cycle();
        req(0, 0, 'h010, 0);    cycle();
        req(1, 1, 'h010, 'h22); cycle();
        req(0, 0, 'h010, 0);    cycle();
        idle(4);

        // four back-to-back reads return on consecutive cycles in order
        for (int i = 0; i < 4; i++) begin req(0, 1, i, 'hA0 + i); cycle(); end
        for (int i = 0; i < 4; i++) begin req(0, 0, i, 0); cycle(); end
        idle(4);

        // random mixed traffic with withdrawals
        auto_mode = 1'b1;
        idle(3000);
        auto_mode = 1'b0;
        for (int p = 0; p < PORTS; p++) p_act[p] = 0;
        idle(6);

        // reset one cycle after a read accept drops that read entirely
        req(0, 1, 'h005, 'h77); cycle();
        req(0, 0, 'h005, 0);    cycle();
        do_reset(1);
        idle(DEPTH + 3);
        req(0, 0, 'h005, 0);    cycle();
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
